// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_ctrl
// Brief   : Debounced three-button stopwatch controller with lap capture.
// Rev     : 1.0
// ============================================================================
module stopwatch_ctrl #(
  parameter int unsigned DEB_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_n,
  input  logic       btn_clear_n,
  input  logic       btn_lap_n,
  input  logic [3:0] t_ms0,
  input  logic [3:0] t_ms1,
  input  logic [3:0] t_s0,
  input  logic [3:0] t_s1,
  input  logic [3:0] t_m0,
  input  logic [3:0] t_m1,
  output logic [1:0] cnt_ctrl,
  output logic       lap_hold,
  output logic [3:0] d_ms0,
  output logic [3:0] d_ms1,
  output logic [3:0] d_s0,
  output logic [3:0] d_s1,
  output logic [3:0] d_m0,
  output logic [3:0] d_m1
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam logic [19:0] DEB_LAST = 20'(DEB_CNT - 1);

  // Bit order: [0] start, [1] clear, [2] lap.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_lap_n, btn_clear_n, btn_start_n};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic        sync1_q;
    logic        sync2_q;
    logic        deb_q;
    logic        deb_prev_q;
    logic        press_q;
    logic [19:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q    <= 1'b1;
        sync2_q    <= 1'b1;
        deb_q      <= 1'b1;
        deb_prev_q <= 1'b1;
        press_q    <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= btn_raw[b];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        press_q    <= deb_prev_q & ~deb_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DEB_LAST) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 20'd1;
        end
      end
    end

    assign press[b] = press_q;
  end

  state_e      state_q, state_d;
  logic        lap_hold_q, lap_hold_d;
  logic [23:0] lap_q, lap_d;
  logic [23:0] disp_q, disp_d;
  logic [23:0] t_live;

  assign t_live = {t_m1, t_m0, t_s1, t_s0, t_ms1, t_ms0};

  // Only the highest-priority event that is legal in the current state acts.
  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;
    if (press[1] && state_q != ST_COUNT) begin
      state_d    = ST_IDLE;
      lap_hold_d = 1'b0;
    end else if (press[0]) begin
      case (state_q)
        ST_IDLE:  state_d = ST_COUNT;
        ST_COUNT: state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_COUNT;
        default:  state_d = ST_IDLE;
      endcase
    end else if (press[2]) begin
      if (state_q == ST_COUNT) begin
        if (lap_hold_q) begin
          lap_hold_d = 1'b0;
        end else begin
          lap_hold_d = 1'b1;
          lap_d      = t_live;
        end
      end else if (state_q == ST_PAUSE && lap_hold_q) begin
        lap_hold_d = 1'b0;
      end
    end
    disp_d = lap_hold_d ? lap_d : t_live;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lap_hold_q <= 1'b0;
      lap_q      <= '0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      lap_hold_q <= lap_hold_d;
      lap_q      <= lap_d;
      disp_q     <= disp_d;
    end
  end

  assign cnt_ctrl = state_q;
  assign lap_hold = lap_hold_q;
  assign d_ms0    = disp_q[3:0];
  assign d_ms1    = disp_q[7:4];
  assign d_s0     = disp_q[11:8];
  assign d_s1     = disp_q[15:12];
  assign d_m0     = disp_q[19:16];
  assign d_m1     = disp_q[23:20];

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_stopwatch_ctrl
// Brief   : Self-checking bench for stopwatch_ctrl against a behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bs, bc, bl;
  logic [23:0] t;
  logic [1:0]  cnt_ctrl;
  logic        lap_hold;
  logic [3:0]  d_ms0, d_ms1, d_s0, d_s1, d_m0, d_m1;
  logic [23:0] dout;

  int n_chk = 0;
  int n_err = 0;
  bit t_fix = 1'b0;

  // Reference model: raw-sample delay line, stability window, press pipeline.
  logic [2:0]     m_dl0, m_dl1, m_deb, m_p1, m_p2;
  logic [DEB-1:0] m_win [3];
  logic [1:0]     m_st;
  logic           m_hold;
  logic [23:0]    m_lap, m_d;

  stopwatch_ctrl #(.DEB_CNT(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_start_n(bs),
    .btn_clear_n(bc),
    .btn_lap_n  (bl),
    .t_ms0      (t[3:0]),
    .t_ms1      (t[7:4]),
    .t_s0       (t[11:8]),
    .t_s1       (t[15:12]),
    .t_m0       (t[19:16]),
    .t_m1       (t[23:20]),
    .cnt_ctrl   (cnt_ctrl),
    .lap_hold   (lap_hold),
    .d_ms0      (d_ms0),
    .d_ms1      (d_ms1),
    .d_s0       (d_s0),
    .d_s1       (d_s1),
    .d_m0       (d_m0),
    .d_m1       (d_m1)
  );

  assign dout = {d_m1, d_m0, d_s1, d_s0, d_ms1, d_ms0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] rand_t();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic model_reset();
    m_dl0 = '1; m_dl1 = '1; m_deb = '1; m_p1 = '0; m_p2 = '0;
    for (int b = 0; b < 3; b++) m_win[b] = '1;
    m_st = 2'd0; m_hold = 1'b0; m_lap = '0; m_d = '0;
  endtask

  task automatic model_edge();
    logic [2:0] raw, act, fell;
    raw  = {bl, bc, bs};
    act  = m_p2;
    m_p2 = m_p1;
    fell = '0;
    for (int b = 0; b < 3; b++) begin
      m_win[b] = {m_win[b][DEB-2:0], m_dl1[b]};
      // Level accepted once the last DEB synchronized samples all disagree.
      if (m_win[b] == {DEB{~m_deb[b]}}) begin
        fell[b]  = m_deb[b];
        m_deb[b] = ~m_deb[b];
      end
    end
    m_dl1 = m_dl0;
    m_dl0 = raw;
    m_p1  = fell;
    if (act[1] && m_st != 2'd1) begin
      m_st = 2'd0; m_hold = 1'b0;
    end else if (act[0]) begin
      m_st = (m_st == 2'd1) ? 2'd2 : 2'd1;
    end else if (act[2]) begin
      if (m_st == 2'd1) begin
        if (m_hold) m_hold = 1'b0;
        else begin m_hold = 1'b1; m_lap = t; end
      end else if (m_st == 2'd2) begin
        m_hold = 1'b0;
      end
    end
    m_d = m_hold ? m_lap : t;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    @(negedge clk);
    chk("cyc", {5'd0, cnt_ctrl, lap_hold, dout}, {5'd0, m_st, m_hold, m_d});
    if (!t_fix) t = rand_t();
  endtask

  task automatic press(input logic [2:0] mask, input int lo, input int hi);
    bs = ~mask[0]; bc = ~mask[1]; bl = ~mask[2];
    repeat (lo) tick();
    bs = 1'b1; bc = 1'b1; bl = 1'b1;
    repeat (hi) tick();
  endtask

  initial begin
    int found;
    rst_n = 1'b0; bs = 1'b1; bc = 1'b1; bl = 1'b1; t = '0;
    model_reset();
    repeat (3) tick();
    chk("reset", {5'd0, cnt_ctrl, lap_hold, dout}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Start held 20 cycles: COUNT exactly DEB+3 edges after the first sampling edge.
    found = -1;
    bs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (found < 0 && cnt_ctrl == 2'b01) found = i;
    end
    chk("start_lat", found, DEB + 3);
    bs = 1'b1;
    repeat (10) tick();
    chk("count", cnt_ctrl, 2'b01);

    press(3'b001, 3, 10);
    chk("glitch", cnt_ctrl, 2'b01);
    press(3'b001, 6, 10);
    chk("pause", cnt_ctrl, 2'b10);
    press(3'b010, 6, 10);
    chk("clear", cnt_ctrl, 2'b00);

    press(3'b001, 6, 10);
    t_fix = 1'b1;
    t = 24'h054321;
    press(3'b100, 6, 3);
    t_fix = 1'b0;
    repeat (5) tick();
    chk("lap_set", lap_hold, 1'b1);
    chk("lap_d", dout, 24'h054321);
    press(3'b100, 6, 10);
    chk("lap_rel", lap_hold, 1'b0);

    press(3'b100, 6, 10);
    press(3'b101, 6, 10);
    chk("sl_cnt", cnt_ctrl, 2'b10);
    chk("sl_hold", lap_hold, 1'b1);
    press(3'b011, 6, 10);
    chk("cs_cnt", cnt_ctrl, 2'b00);
    chk("cs_hold", lap_hold, 1'b0);

    press(3'b001, 6, 10);
    press(3'b100, 6, 10);
    chk("pre_rst", {cnt_ctrl, lap_hold}, 3'b011);
    #1 rst_n = 1'b0;
    bs = 1'b0;
    #1 chk("async_rst", {5'd0, cnt_ctrl, lap_hold, dout}, 32'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    found = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (found < 0 && cnt_ctrl == 2'b01) found = i;
    end
    chk("rst_lat", found, DEB + 3);
    bs = 1'b1;
    repeat (10) tick();

    for (int it = 0; it < 250; it++) begin
      logic [2:0] mask;
      if ($urandom_range(0, 3) == 0) mask = 3'($urandom_range(1, 7));
      else mask = 3'(1 << $urandom_range(0, 2));
      press(mask, $urandom_range(1, 9), $urandom_range(1, 9));
    end
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
